// File: rtl/dot_prod_engine.sv
// Dot-product engine: two host-loadable signed operand arrays and a pipelined MAC
// that computes init_acc + sum(A[k]*B[k]) over a wrapping address window.
module dot_prod_engine #(
    parameter int DATA_W = 27,
    parameter int ADDR_W = 10,
    parameter int ACC_W  = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ctrl_en,
    input  logic                     ctrl_we_a,
    input  logic [ADDR_W-1:0]        ctrl_addr_a,
    input  logic signed [DATA_W-1:0] ctrl_wdata_a,
    output logic signed [DATA_W-1:0] ctrl_rdata_a,
    input  logic                     ctrl_we_b,
    input  logic [ADDR_W-1:0]        ctrl_addr_b,
    input  logic signed [DATA_W-1:0] ctrl_wdata_b,
    output logic signed [DATA_W-1:0] ctrl_rdata_b,
    input  logic                     r_enable,
    input  logic [ADDR_W-1:0]        start_addr,
    input  logic [ADDR_W:0]          len,
    input  logic signed [ACC_W-1:0]  init_acc,
    input  logic                     sat_en,
    output logic                     busy,
    output logic                     w_enable,
    output logic signed [ACC_W-1:0]  result,
    output logic                     overflow
);

    localparam int DEPTH  = 1 << ADDR_W;
    localparam int PROD_W = 2 * DATA_W;
    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t              state_reg;
    logic                host_act;
    logic                start_ok;

    // Issue stage
    logic [ADDR_W-1:0]   addr_reg;
    logic [ADDR_W-1:0]   next_addr_reg;
    logic [ADDR_W:0]     cnt_reg;
    logic                a_vld_reg;
    logic                a_last_reg;
    logic                sat_reg;

    // Read, product and accumulate stages
    logic                r_vld_reg;
    logic                r_last_reg;
    logic                p_vld_reg;
    logic                p_last_reg;
    logic                fin_reg;
    logic signed [PROD_W-1:0] prod_reg;
    logic signed [ACC_W-1:0]  acc_reg;
    logic                ovf_reg;

    logic signed [DATA_W-1:0] rd_a;
    logic signed [DATA_W-1:0] rd_b;
    logic signed [PROD_W-1:0] ext_a;
    logic signed [PROD_W-1:0] ext_b;
    logic signed [PROD_W-1:0] prod_next;
    logic signed [ACC_W-1:0]  prod_ext;
    logic [ACC_W:0]           sum_full;
    logic                     add_ovf;
    logic signed [ACC_W-1:0]  acc_next;

    // Per-array views so both memories come from one generate body
    logic                     we_v    [2];
    logic [ADDR_W-1:0]        haddr_v [2];
    logic [DATA_W-1:0]        wdata_v [2];
    logic [DATA_W-1:0]        hrd_v   [2];
    logic [DATA_W-1:0]        erd_v   [2];

    assign host_act = ctrl_en && (state_reg == IDLE);
    assign start_ok = r_enable && !ctrl_en && (state_reg == IDLE);

    assign we_v[0]    = ctrl_we_a;
    assign we_v[1]    = ctrl_we_b;
    assign haddr_v[0] = ctrl_addr_a;
    assign haddr_v[1] = ctrl_addr_b;
    assign wdata_v[0] = ctrl_wdata_a;
    assign wdata_v[1] = ctrl_wdata_b;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_mem
            logic [DATA_W-1:0] mem [DEPTH];
            logic [DATA_W-1:0] eng_q_reg;
            logic [DATA_W-1:0] host_q_reg;

            // Contents survive reset; the engine read port is free-running
            always_ff @(posedge clk) begin
                if (host_act && we_v[gi]) begin
                    mem[haddr_v[gi]] <= wdata_v[gi];
                end
                eng_q_reg <= mem[addr_reg];
            end

            // Host read data only moves while the host owns the arrays
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    host_q_reg <= '0;
                end else if (host_act) begin
                    host_q_reg <= mem[haddr_v[gi]];
                end
            end

            assign hrd_v[gi] = host_q_reg;
            assign erd_v[gi] = eng_q_reg;
        end
    endgenerate

    assign ctrl_rdata_a = hrd_v[0];
    assign ctrl_rdata_b = hrd_v[1];
    assign rd_a         = erd_v[0];
    assign rd_b         = erd_v[1];

    assign ext_a     = PROD_W'(rd_a);
    assign ext_b     = PROD_W'(rd_b);
    assign prod_next = ext_a * ext_b;
    assign prod_ext  = ACC_W'(prod_reg);

    // One guard bit: overflow is a disagreement between the guard and the sign
    assign sum_full = {acc_reg[ACC_W-1], acc_reg} + {prod_ext[ACC_W-1], prod_ext};
    assign add_ovf  = sum_full[ACC_W] ^ sum_full[ACC_W-1];

    always_comb begin
        acc_next = sum_full[ACC_W-1:0];
        if (add_ovf && sat_reg) begin
            acc_next = sum_full[ACC_W] ? ACC_MIN : ACC_MAX;
        end
    end

    // Control FSM: the first address is issued on the accepting edge itself
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            busy          <= 1'b0;
            w_enable      <= 1'b0;
            result        <= '0;
            addr_reg      <= '0;
            next_addr_reg <= '0;
            cnt_reg       <= '0;
            a_vld_reg     <= 1'b0;
            a_last_reg    <= 1'b0;
            sat_reg       <= 1'b0;
        end else begin
            w_enable   <= 1'b0;
            a_vld_reg  <= 1'b0;
            a_last_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start_ok) begin
                        busy    <= 1'b1;
                        sat_reg <= sat_en;
                        if (len == '0) begin
                            state_reg <= DONE;
                            w_enable  <= 1'b1;
                            result    <= init_acc;
                        end else begin
                            state_reg     <= ISSUE;
                            addr_reg      <= start_addr;
                            next_addr_reg <= start_addr + 1'b1;
                            cnt_reg       <= len - 1'b1;
                            a_vld_reg     <= 1'b1;
                            a_last_reg    <= (len == (ADDR_W+1)'(1));
                        end
                    end
                end
                ISSUE: begin
                    if (cnt_reg == '0) begin
                        state_reg <= DRAIN;
                    end else begin
                        addr_reg      <= next_addr_reg;
                        next_addr_reg <= next_addr_reg + 1'b1;
                        cnt_reg       <= cnt_reg - 1'b1;
                        a_vld_reg     <= 1'b1;
                        a_last_reg    <= (cnt_reg == (ADDR_W+1)'(1));
                        if (cnt_reg == (ADDR_W+1)'(1)) begin
                            state_reg <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (fin_reg) begin
                        state_reg <= DONE;
                        w_enable  <= 1'b1;
                        result    <= acc_reg;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                    busy      <= 1'b0;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Datapath: valid/last flags travel alongside read data and products
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld_reg  <= 1'b0;
            r_last_reg <= 1'b0;
            p_vld_reg  <= 1'b0;
            p_last_reg <= 1'b0;
            fin_reg    <= 1'b0;
            prod_reg   <= '0;
            acc_reg    <= '0;
            ovf_reg    <= 1'b0;
        end else begin
            r_vld_reg  <= a_vld_reg;
            r_last_reg <= a_last_reg;
            p_vld_reg  <= r_vld_reg;
            p_last_reg <= r_last_reg;
            fin_reg    <= p_vld_reg && p_last_reg;
            if (r_vld_reg) begin
                prod_reg <= prod_next;
            end
            if (start_ok) begin
                acc_reg <= init_acc;
                ovf_reg <= 1'b0;
            end else if (p_vld_reg) begin
                acc_reg <= acc_next;
                if (add_ovf) begin
                    ovf_reg <= 1'b1;
                end
            end
        end
    end

    assign overflow = ovf_reg;

endmodule
